uart_loader: RTL

Bus-initiator boot loader that drives the UART register slave from the master side. It polls the UART status register, reads received bytes, assembles them into little-endian 32-bit words and writes them to a word-addressed memory port. It sits between the UART slave and the memory bus and is used to download a program image before the CPU is released from reset.

---
 rtl/uart_loader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/uart_loader.sv
// Boot loader that acts as bus initiator on a UART register slave: polls RX_END, clears it,
// reads each byte, packs little-endian words and writes them to a word-addressed memory port.
module uart_loader #(
   parameter logic [29:0] BASE_ADDR = 30'h0,
   parameter int          POLL_GAP  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        u_cs,
   output logic        u_as,
   output logic        u_rw,
   output logic        u_addr,
   output logic [31:0] u_wr_data,
   input  logic [31:0] u_rd_data,
   input  logic        u_rdy,
   output logic        mem_req,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wr_data,
   input  logic        mem_ack,
   output logic [31:0] word_cnt
);

   // Handshakes: a UART access holds cs/as/rw/addr until u_rdy is sampled high, then spends
   // exactly one idle (gap) cycle before the next step; mem_req holds address/data until
   // mem_ack is sampled high and drops the following cycle.
   typedef enum logic [2:0] {
      S_IDLE, S_POLL, S_WAIT, S_CLR, S_RDDATA, S_MEMWR, S_DONE
   } state_t;

   localparam int GW = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
   localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

   state_t        r_state;
   state_t        w_next_state;
   logic          r_gap;
   logic          r_status;
   logic [31:0]   r_word;
   logic [1:0]    r_idx;
   logic          r_hdr;
   logic [31:0]   r_n;
   logic [31:0]   r_word_cnt;
   logic          r_done;
   logic [GW-1:0] r_wait_cnt;
   logic          w_access;
   logic          w_unused;

   assign w_access = ((r_state == S_POLL) || (r_state == S_CLR) || (r_state == S_RDDATA)) && !r_gap;
   assign w_unused = ^u_rd_data[31:8];

   // State register
   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_next_state;
   end

   // Next-state logic; every UART step decides only after its gap cycle
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (start) w_next_state = S_POLL;
         S_POLL:   if (r_gap) w_next_state = r_status ? S_CLR : ((POLL_GAP == 0) ? S_POLL : S_WAIT);
         S_WAIT:   if (r_wait_cnt == GAP_LAST) w_next_state = S_POLL;
         S_CLR:    if (r_gap) w_next_state = S_RDDATA;
         S_RDDATA: begin
            if (r_gap) begin
               if (r_idx != 2'd0)  w_next_state = S_POLL;
               else if (!r_hdr)    w_next_state = S_MEMWR;
               else                w_next_state = (r_word == 32'h0) ? S_DONE : S_POLL;
            end
         end
         S_MEMWR:  if (mem_ack) w_next_state = ((r_word_cnt + 32'd1) == r_n) ? S_DONE : S_POLL;
         S_DONE:   w_next_state = S_IDLE;
         default:  w_next_state = S_IDLE;
      endcase
   end

   // Datapath: byte packing, header capture, word counter, poll gap timer
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_gap      <= 1'b0;
         r_status   <= 1'b0;
         r_word     <= 32'h0;
         r_idx      <= 2'd0;
         r_hdr      <= 1'b1;
         r_n        <= 32'h0;
         r_word_cnt <= 32'h0;
         r_done     <= 1'b0;
         r_wait_cnt <= '0;
      end else begin
         r_gap <= w_access && u_rdy;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_done     <= 1'b0;
                  r_word_cnt <= 32'h0;
                  r_idx      <= 2'd0;
                  r_hdr      <= 1'b1;
               end
            end
            S_POLL: begin
               r_wait_cnt <= '0;
               if (w_access && u_rdy) r_status <= u_rd_data[0];
            end
            S_WAIT: r_wait_cnt <= r_wait_cnt + 1'b1;
            S_RDDATA: begin
               if (w_access && u_rdy) begin
                  r_word[{r_idx, 3'b000} +: 8] <= u_rd_data[7:0];
                  r_idx                        <= r_idx + 2'd1;
               end
               if (r_gap && (r_idx == 2'd0) && r_hdr) begin
                  r_n   <= r_word;
                  r_hdr <= 1'b0;
               end
            end
            S_MEMWR: if (mem_ack) r_word_cnt <= r_word_cnt + 32'd1;
            default: ;
         endcase
         if (w_next_state == S_DONE) r_done <= 1'b1;
      end
   end

   // Outputs; address/data are gated so that every output idles at zero
   always_comb begin
      u_cs        = w_access;
      u_as        = w_access;
      u_rw        = w_access && (r_state != S_CLR);
      u_addr      = w_access && (r_state == S_RDDATA);
      mem_req     = (r_state == S_MEMWR);
      mem_addr    = 30'h0;
      mem_wr_data = 32'h0;
      if (r_state == S_MEMWR) begin
         mem_addr    = BASE_ADDR + r_word_cnt[29:0];
         mem_wr_data = r_word;
      end
      busy     = (r_state != S_IDLE) && (r_state != S_DONE);
      done     = r_done;
      word_cnt = r_word_cnt;
   end

   assign u_wr_data = 32'h0;

endmodule
